mem_responder: RTL and testbench

//  Responder end of the core-to-memory bus: the core drives addr/data/write_enable, and this block returns

---
 rtl/mem_responder.sv | 136 +++++++++++++
 tb/tb_mem_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Responder end of the core-to-memory bus: dual-port code/data RAM (core on port A,
// program loader on port B) plus an 8-word memory-mapped I/O page.
module mem_responder #(
    parameter int          RAM_AW  = 15,
    parameter logic [23:0] IO_BASE = 24'hFF0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [23:0]       core_to_mem_addr,
    input  logic [15:0]       core_to_mem_data,
    input  logic              core_to_mem_write_enable,
    output logic [15:0]       mem_to_core_data,
    input  logic              load_valid,
    input  logic [RAM_AW-1:0] load_addr,
    input  logic [15:0]       load_data,
    output logic              load_ready,
    input  logic [15:0]       sw_in,
    output logic [15:0]       led_out
);

    localparam int RAM_WORDS = 2 ** RAM_AW;

    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_RAM,
        SEL_IO
    } rd_sel_e;

    logic [15:0] ram_q [RAM_WORDS];
    logic [15:0] ram_rdata_q;

    rd_sel_e     sel_q, sel_d;
    logic [15:0] io_rdata_q, io_rdata_d;
    logic [15:0] led_q, led_d;
    logic [15:0] sw_meta_q, sw_sync_q;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] cnt_hi_q, cnt_hi_d;
    logic        bad_q, bad_d;

    logic        in_ram, io_hit, core_ram_we, load_fire;
    logic [2:0]  io_off;

    assign in_ram      = (core_to_mem_addr >> RAM_AW) == 24'd0;
    assign io_hit      = core_to_mem_addr[23:3] == IO_BASE[23:3];
    assign io_off      = core_to_mem_addr[2:0];
    assign core_ram_we = rst_n & core_to_mem_write_enable & in_ram;
    // The core owns the shared write path whenever it writes RAM; the loader waits.
    assign load_ready  = rst_n & ~(core_to_mem_write_enable & in_ram);
    assign load_fire   = load_valid & load_ready;
    assign led_out     = led_q;

    // Read-first RAM: the registered read sees the word from before either write.
    always_ff @(posedge clk) begin
        if (core_ram_we) begin
            ram_q[core_to_mem_addr[RAM_AW-1:0]] <= core_to_mem_data;
        end
        if (load_fire) begin
            ram_q[load_addr] <= load_data;
        end
        ram_rdata_q <= ram_q[core_to_mem_addr[RAM_AW-1:0]];
    end

    always_comb begin
        led_d      = led_q;
        cnt_d      = cnt_q + 32'd1;
        cnt_hi_d   = cnt_hi_q;
        bad_d      = bad_q;
        sel_d      = SEL_ZERO;
        io_rdata_d = 16'h0000;
        case (io_off)
            3'd0:    io_rdata_d = led_q;
            3'd1:    io_rdata_d = sw_sync_q;
            3'd2:    io_rdata_d = cnt_q[15:0];
            3'd3:    io_rdata_d = cnt_hi_q;
            3'd4:    io_rdata_d = {15'b0, bad_q};
            default: io_rdata_d = 16'h0000;
        endcase
        if (core_to_mem_write_enable) begin
            if (in_ram) begin
                sel_d = SEL_ZERO;
            end else if (io_hit) begin
                if (io_off == 3'd0) begin
                    led_d = core_to_mem_data;
                end
                if (io_off == 3'd4 && core_to_mem_data[0]) begin
                    bad_d = 1'b0;
                end
            end else begin
                bad_d = 1'b1;
            end
        end else begin
            if (in_ram) begin
                sel_d = SEL_RAM;
            end else if (io_hit) begin
                sel_d = SEL_IO;
                if (io_off == 3'd2) begin
                    cnt_hi_d = cnt_q[31:16];
                end
            end else begin
                bad_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q      <= SEL_ZERO;
            io_rdata_q <= 16'h0000;
            led_q      <= 16'h0000;
            sw_meta_q  <= 16'h0000;
            sw_sync_q  <= 16'h0000;
            cnt_q      <= 32'd0;
            cnt_hi_q   <= 16'h0000;
            bad_q      <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            io_rdata_q <= io_rdata_d;
            led_q      <= led_d;
            sw_meta_q  <= sw_in;
            sw_sync_q  <= sw_meta_q;
            cnt_q      <= cnt_d;
            cnt_hi_q   <= cnt_hi_d;
            bad_q      <= bad_d;
        end
    end

    always_comb begin
        mem_to_core_data = 16'h0000;
        case (sel_q)
            SEL_RAM: mem_to_core_data = ram_rdata_q;
            SEL_IO:  mem_to_core_data = io_rdata_q;
            default: mem_to_core_data = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, hand-written corner sequences,
// then randomized bus/loader traffic checked against a behavioural memory model.
module tb_mem_responder;

    localparam logic [23:0] IO = 24'hFF0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] core_to_mem_addr;
    logic [15:0] core_to_mem_data;
    logic        core_to_mem_write_enable;
    logic [15:0] mem_to_core_data;
    logic        load_valid;
    logic [14:0] load_addr;
    logic [15:0] load_data;
    logic        load_ready;
    logic [15:0] sw_in;
    logic [15:0] led_out;

    int vectors = 0;
    int miscompares = 0;

    mem_responder #(.RAM_AW(15), .IO_BASE(IO)) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .core_to_mem_addr         (core_to_mem_addr),
        .core_to_mem_data         (core_to_mem_data),
        .core_to_mem_write_enable (core_to_mem_write_enable),
        .mem_to_core_data         (mem_to_core_data),
        .load_valid               (load_valid),
        .load_addr                (load_addr),
        .load_data                (load_data),
        .load_ready               (load_ready),
        .sw_in                    (sw_in),
        .led_out                  (led_out)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [15:0] m_mem [int];
    logic [15:0] m_led, m_hi, m_sw;
    logic        m_bad;
    logic [31:0] m_cnt;

    function automatic void model_reset();
        m_led = 16'h0; m_hi = 16'h0; m_bad = 1'b0; m_cnt = 32'd0;
    endfunction

    // One bus cycle of the model; returns expected read data (and whether it is known) and load_ready.
    function automatic void model_step(input logic [23:0] a, input logic [15:0] d, input logic w,
                                       input logic lv, input logic [14:0] la, input logic [15:0] ld,
                                       output logic [15:0] eo, output logic known, output logic er);
        bit ram = (a < 24'd32768);
        bit io  = (a >= IO) && (a < IO + 24'd8);
        int off = int'(a - IO);
        eo = 16'h0; known = 1'b1;
        er = !(w && ram);
        if (w) begin
            if (ram) m_mem[int'(a)] = d;
            else if (io) begin
                if (off == 0) m_led = d;
                if (off == 4 && d[0]) m_bad = 1'b0;
            end else m_bad = 1'b1;
        end else if (ram) begin
            known = m_mem.exists(int'(a));
            if (known) eo = m_mem[int'(a)];
        end else if (io) begin
            case (off)
                0: eo = m_led;
                1: eo = m_sw;
                2: begin eo = m_cnt[15:0]; m_hi = m_cnt[31:16]; end
                3: eo = m_hi;
                4: eo = {15'b0, m_bad};
                default: eo = 16'h0;
            endcase
        end else m_bad = 1'b1;
        if (lv && er) m_mem[int'(la)] = ld;
        m_cnt = m_cnt + 32'd1;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Called just after a posedge: drive inputs, sample load_ready mid-cycle, sample read data after the edge.
    task automatic step(input logic [23:0] a, input logic [15:0] d, input logic w,
                        input logic lv, input logic [14:0] la, input logic [15:0] ld,
                        output logic [15:0] got, output logic got_rdy);
        core_to_mem_addr = a; core_to_mem_data = d; core_to_mem_write_enable = w;
        load_valid = lv; load_addr = la; load_data = ld;
        #2;
        got_rdy = load_ready;
        @(posedge clk);
        #1;
        got = mem_to_core_data;
    endtask

    // Step the DUT and model together and compare everything the model knows.
    task automatic mstep(input string name, input logic [23:0] a, input logic [15:0] d, input logic w,
                         input logic lv, input logic [14:0] la, input logic [15:0] ld,
                         output logic got_rdy);
        logic [15:0] got, eo;
        logic known, er;
        model_step(a, d, w, lv, la, ld, eo, known, er);
        step(a, d, w, lv, la, ld, got, got_rdy);
        check({name, ".ready"}, 32'(got_rdy), 32'(er));
        if (known) check({name, ".rdata"}, 32'(got), 32'(eo));
        check({name, ".led"}, 32'(led_out), 32'(m_led));
    endtask

    typedef struct {
        logic [23:0] addr; logic [15:0] data; logic we;
        logic lv; logic [14:0] la; logic [15:0] ld;
        logic rdy; logic [15:0] out; logic [15:0] led;
    } vec_t;

    initial begin
        vec_t        tbl[$];
        logic [15:0] got, eo;
        logic        rdy, known, er;
        logic        pend;
        logic [14:0] p_la;
        logic [15:0] p_ld;

        tbl.push_back('{IO+2,      16'h0,    0, 0, 15'h0,  16'h0,    1, 16'h0000, 16'h0});    // CNT_LO from 0
        tbl.push_back('{24'h004000, 16'h1234, 1, 0, 15'h0,  16'h0,    0, 16'h0000, 16'h0});
        tbl.push_back('{24'h004000, 16'h0,    0, 0, 15'h0,  16'h0,    1, 16'h1234, 16'h0});
        tbl.push_back('{24'h004000, 16'h0,    0, 1, 15'h10, 16'h1111, 1, 16'h1234, 16'h0});
        tbl.push_back('{24'h000010, 16'h0,    0, 1, 15'h10, 16'h2222, 1, 16'h1111, 16'h0});   // read-first vs loader
        tbl.push_back('{24'h000010, 16'h0,    0, 0, 15'h0,  16'h0,    1, 16'h2222, 16'h0});
        tbl.push_back('{24'h000021, 16'h5555, 1, 1, 15'h20, 16'hABCD, 0, 16'h0000, 16'h0});   // loader stalled
        tbl.push_back('{IO+0,      16'h0,    0, 1, 15'h20, 16'hABCD, 1, 16'h0000, 16'h0});
        tbl.push_back('{24'h000020, 16'h0,    0, 0, 15'h0,  16'h0,    1, 16'hABCD, 16'h0});
        tbl.push_back('{24'h000021, 16'h0,    0, 0, 15'h0,  16'h0,    1, 16'h5555, 16'h0});
        tbl.push_back('{IO+0,      16'hBEEF, 1, 0, 15'h0,  16'h0,    1, 16'h0000, 16'hBEEF});
        tbl.push_back('{IO+0,      16'h0,    0, 0, 15'h0,  16'h0,    1, 16'hBEEF, 16'hBEEF});
        tbl.push_back('{IO+1,      16'h7777, 1, 0, 15'h0,  16'h0,    1, 16'h0000, 16'hBEEF});
        tbl.push_back('{IO+1,      16'h0,    0, 0, 15'h0,  16'h0,    1, 16'hA5C3, 16'hBEEF});
        tbl.push_back('{24'h800000, 16'h9999, 1, 0, 15'h0,  16'h0,    1, 16'h0000, 16'hBEEF}); // illegal write
        tbl.push_back('{IO+4,      16'h0,    0, 0, 15'h0,  16'h0,    1, 16'h0001, 16'hBEEF});
        tbl.push_back('{IO+5,      16'h0,    0, 0, 15'h0,  16'h0,    1, 16'h0000, 16'hBEEF});
        tbl.push_back('{IO+4,      16'h0000, 1, 0, 15'h0,  16'h0,    1, 16'h0000, 16'hBEEF});
        tbl.push_back('{IO+4,      16'h0,    0, 0, 15'h0,  16'h0,    1, 16'h0001, 16'hBEEF});
        tbl.push_back('{IO+4,      16'h0001, 1, 0, 15'h0,  16'h0,    1, 16'h0000, 16'hBEEF});
        tbl.push_back('{IO+4,      16'h0,    0, 0, 15'h0,  16'h0,    1, 16'h0000, 16'hBEEF});
        tbl.push_back('{24'h800001, 16'h0,    0, 0, 15'h0,  16'h0,    1, 16'h0000, 16'hBEEF}); // illegal read
        tbl.push_back('{IO+4,      16'h0,    0, 0, 15'h0,  16'h0,    1, 16'h0001, 16'hBEEF});
        tbl.push_back('{IO+4,      16'h0001, 1, 0, 15'h0,  16'h0,    1, 16'h0000, 16'hBEEF});
        tbl.push_back('{IO+6,      16'hFFFF, 1, 0, 15'h0,  16'h0,    1, 16'h0000, 16'hBEEF}); // reserved write
        tbl.push_back('{IO+4,      16'h0,    0, 0, 15'h0,  16'h0,    1, 16'h0000, 16'hBEEF});
        tbl.push_back('{24'h004000, 16'h0,    0, 0, 15'h0,  16'h0,    1, 16'h1234, 16'hBEEF});

        // Reset with the loader presenting a word that must not land
        sw_in = 16'hA5C3; m_sw = 16'hA5C3;
        rst_n = 1'b0;
        core_to_mem_addr = 24'h000010; core_to_mem_data = 16'hDEAD; core_to_mem_write_enable = 1'b0;
        load_valid = 1'b1; load_addr = 15'h10; load_data = 16'h5A5A;
        repeat (2) @(posedge clk);
        #1;
        check("reset.rdata", 32'(mem_to_core_data), 32'h0);
        check("reset.led", 32'(led_out), 32'h0);
        check("reset.ready", 32'(load_ready), 32'h0);
        rst_n = 1'b1;
        model_reset();

        foreach (tbl[i]) begin
            model_step(tbl[i].addr, tbl[i].data, tbl[i].we, tbl[i].lv, tbl[i].la, tbl[i].ld, eo, known, er);
            step(tbl[i].addr, tbl[i].data, tbl[i].we, tbl[i].lv, tbl[i].la, tbl[i].ld, got, rdy);
            check($sformatf("vec%0d.ready", i), 32'(rdy), 32'(tbl[i].rdy));
            check($sformatf("vec%0d.rdata", i), 32'(got), 32'(tbl[i].out));
            check($sformatf("vec%0d.led", i), 32'(led_out), 32'(tbl[i].led));
        end

        // Coherent 32-bit counter snapshot across a low-half carry
        force dut.cnt_q = 32'h0001FFFF;
        #1;
        release dut.cnt_q;
        m_cnt = 32'h0001FFFF;
        mstep("cnt_lo", IO+2, 16'h0, 0, 0, 15'h0, 16'h0, rdy);
        step(IO+3, 16'h0, 0, 0, 15'h0, 16'h0, got, rdy);
        model_step(IO+3, 16'h0, 0, 0, 15'h0, 16'h0, eo, known, er);
        check("cnt_hi.snapshot", 32'(got), 32'h0001);
        mstep("cnt_lo2", IO+2, 16'h0, 0, 0, 15'h0, 16'h0, rdy);

        // Randomized traffic with a handshake-obeying loader
        pend = 1'b0; p_la = '0; p_ld = '0;
        for (int n = 0; n < 400; n++) begin
            logic [23:0] a;
            int r = int'($urandom_range(0, 9));
            if (r < 6)      a = 24'h000100 + 24'($urandom_range(0, 15));
            else if (r < 9) a = IO + 24'($urandom_range(0, 7));
            else            a = 24'h800000 + 24'($urandom_range(0, 255));
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1'b1;
                p_la = 15'h100 + 15'($urandom_range(0, 15));
                p_ld = 16'($urandom);
            end
            mstep($sformatf("rand%0d", n), a, 16'($urandom), 1'($urandom), pend, p_la, p_ld, rdy);
            if (pend && rdy) pend = 1'b0;
        end

        // Reset in the middle of a loader transfer: the word is dropped and re-presented
        mstep("midload.pre", 24'h000030, 16'h1010, 1, 0, 15'h0, 16'h0, rdy);
        mstep("midload.led", IO+0, 16'h4242, 1, 0, 15'h0, 16'h0, rdy);
        rst_n = 1'b0;
        core_to_mem_addr = 24'h000031; core_to_mem_write_enable = 1'b0;
        load_valid = 1'b1; load_addr = 15'h30; load_data = 16'h7777;
        #2;
        check("midload.ready_in_reset", 32'(load_ready), 32'h0);
        @(posedge clk);
        #1;
        check("midload.rdata_reset", 32'(mem_to_core_data), 32'h0);
        check("midload.led_reset", 32'(led_out), 32'h0);
        rst_n = 1'b1;
        model_reset();
        mstep("midload.cnt0", IO+2, 16'h0, 0, 0, 15'h0, 16'h0, rdy);
        mstep("midload.old", 24'h000030, 16'h0, 0, 0, 15'h0, 16'h0, rdy);
        mstep("midload.retry", IO+4, 16'h0, 0, 1, 15'h30, 16'h7777, rdy);
        mstep("midload.new", 24'h000030, 16'h0, 0, 0, 15'h0, 16'h0, rdy);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
